// File: rtl/arm_mul_unit.sv
// Iterative MUL/MLA unit: retires STEP multiplier bits per cycle behind a start/busy/done handshake.
// Build option ARM_MUL_LONG_EN: 2*WIDTH accumulator and result_hi output for UMULL/UMLAL-style results.
module arm_mul_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             acc_en,
  input  logic             s_bit,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] acc_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             flag_we
`ifdef ARM_MUL_LONG_EN
  ,
  output logic [WIDTH-1:0] result_hi
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one partial-product step per cycle, busy=1
  // DONE  | one-cycle done pulse; start here chains the next operation

`ifdef ARM_MUL_LONG_EN
  localparam int ACCW = 2 * WIDTH;
`else
  localparam int ACCW = WIDTH;
`endif
  localparam int NSTEP = WIDTH / STEP;
  localparam int CW    = $clog2(NSTEP + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ACCW-1:0]   r_a;
  logic [ACCW-1:0]   r_acc;
  logic [WIDTH-1:0]  r_b;
  logic [CW-1:0]     r_cnt;
  logic              r_s;
  logic [WIDTH-1:0]  r_result;
`ifdef ARM_MUL_LONG_EN
  logic [WIDTH-1:0]  r_result_hi;
`endif
  logic [3:0]        r_flags;
  logic [ACCW-1:0]   w_partial;
  logic [ACCW-1:0]   w_acc_sum;
  logic              w_load;
  logic              w_last;

  assign w_last = (r_state == S_RUN) && (r_cnt == CW'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift-and-add over the STEP low multiplier bits; bits shifted past ACCW are dropped.
  always_comb begin
    w_partial = '0;
    for (int i = 0; i < STEP; i++) begin
      if (r_b[i]) w_partial = w_partial + (r_a << i);
    end
  end

  assign w_acc_sum = r_acc + w_partial;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_s         <= 1'b0;
      r_result    <= '0;
`ifdef ARM_MUL_LONG_EN
      r_result_hi <= '0;
`endif
      r_flags     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_a   <= ACCW'(a_in);
        r_b   <= b_in;
        r_s   <= s_bit;
        r_acc <= acc_en ? ACCW'(acc_in) : '0;
        r_cnt <= CW'(NSTEP);
      end else if (r_state == S_RUN) begin
        r_a   <= r_a << STEP;
        r_b   <= r_b >> STEP;
        r_acc <= w_acc_sum;
        r_cnt <= r_cnt - CW'(1);
      end
      // The final step's sum goes straight to the outputs so DONE shows it immediately.
      if (w_last) begin
        r_result    <= w_acc_sum[WIDTH-1:0];
`ifdef ARM_MUL_LONG_EN
        r_result_hi <= w_acc_sum[ACCW-1:WIDTH];
`endif
        r_flags     <= {w_acc_sum[ACCW-1], (w_acc_sum == '0), 2'b00};
      end
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign result  = r_result;
  assign flags   = r_flags;
  assign flag_we = done & r_s;
`ifdef ARM_MUL_LONG_EN
  assign result_hi = r_result_hi;
`endif

endmodule

// File: doc/arm_mul_unit.md
Name: arm_mul_unit

Overview:
- Parametrised iterative multiply/multiply-accumulate unit for the ARM core datapath; successor to the combinational 2-bit-control ALU.
- Executes MUL and MLA (Rd <- Rn*Rm [+ Ra]) over multiple cycles with a start/busy/done handshake, and produces N/Z flags in the ALU flag-nibble format.
- The controller stalls PC/register writeback while busy is high, then writes result and flags on done.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and >= 8.
- STEP, 1, multiplier bits retired per cycle; must divide WIDTH exactly (1, 2, 4 legal).

Ports:
- clk  input  1  core clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- acc_en  input  1  1 = MLA (add acc_in), 0 = MUL
- s_bit  input  1  instruction S bit; captured with operands
- a_in  input  WIDTH  multiplicand (Rm)
- b_in  input  WIDTH  multiplier (Rs)
- acc_in  input  WIDTH  accumulate operand (Rn); ignored when acc_en=0
- busy  output  1  high in RUN state
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  low WIDTH bits of product(+acc)
- flags  output  4  {N,Z,C,V}; C and V always 0
- flag_we  output  1  equals done & captured s_bit

Behaviour:
- Clock is clk; reset is synchronous and active-high; no asynchronous reset anywhere.
- FSM states: IDLE, RUN, DONE. Reset -> IDLE. All outputs 0 at reset (busy=0, done=0, result=0, flags=0, flag_we=0).
- IDLE: start=1 at a rising edge -> capture a_in, b_in, s_bit; accumulator <= acc_en ? acc_in : 0; counter <= WIDTH/STEP; go to RUN.
- RUN: each cycle, accumulator += a_shifted * (low STEP bits of b_shifted); a shifts left by STEP, b shifts right by STEP; counter decrements. When counter reaches 1 at an edge -> DONE.
- DONE: done=1 for exactly one cycle. result and flags update on entry to DONE and hold until the next DONE. If start=1 in DONE -> capture new operands and go to RUN (back-to-back); else -> IDLE.
- busy=1 only in RUN. start is ignored while busy=1; operand inputs are don't-care while busy=1.
- Latency: done asserts WIDTH/STEP+1 cycles after the edge that samples start (33 cycles for WIDTH=32, STEP=1).
- Arithmetic: unsigned; result = (a*b + acc) mod 2^WIDTH; overflow is discarded silently.
- Flags: N = result[WIDTH-1]; Z = (result == 0); C = V = 0. flags hold between operations; flag_we pulses with done only when s_bit=1.
- Synchronous reset during RUN or DONE: return to IDLE, the in-flight operation is discarded, no done pulse, and outputs clear to 0.
- b_in = 0 or a_in = 0: still runs the full latency (no early exit); result = acc.

Optional Feature:
- Macro ARM_MUL_LONG_EN.
- Defined: adds output result_hi (WIDTH) holding upper WIDTH bits of the unsigned 2*WIDTH-bit a*b+acc (UMULL/UMLAL-style). The internal accumulator is 2*WIDTH wide. Z = (result_hi == 0 & result == 0); N = result_hi[WIDTH-1]. Latency is unchanged. result_hi resets to 0.
- Undefined: no result_hi port; accumulator is WIDTH bits; flags derive from result only.

Test Plan (WIDTH=32, STEP=1 unless noted):
- Pulse start, a=7, b=6, acc_en=0, s_bit=1 -> busy high 32 cycles; done on cycle 33; result=42; flags=4'b0000; flag_we=1.
- a=3, b=4, acc=100, acc_en=1, s_bit=0 -> result=112; flag_we=0; flags unchanged from previous op.
- a=0xFFFFFFFF, b=2, s_bit=1 -> result=0xFFFFFFFE, N=1, Z=0. Then a=0x10000, b=0x10000 -> result=0, Z=1.
- Hold start=1 continuously -> second op accepted in the DONE cycle; exactly one done pulse per 33 cycles. start pulses while busy -> ignored, no extra done.
- Assert reset for 1 cycle at cycle 10 of RUN -> next cycle busy=0, result=0, no done. New start then completes normally.
- STEP=4 build: 7*6 -> done at cycle 9, result=42. ARM_MUL_LONG_EN build: 0xFFFFFFFF*0xFFFFFFFF -> result_hi=0xFFFFFFFE, result=0x00000001.
